// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StIssue,
    StFault
  } fetch_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake plus control-unit and fault signals.
interface instr_fetch_unit_if;

  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        fault_clear;

  modport master (
    input  PCSrc, PCTarget, hold, imem_ack, imem_rdata, fault_clear,
    output imem_req, imem_addr, Instr, Instr_valid, PC, PCPlus4, fault, fault_cause
  );

  modport slave (
    output PCSrc, PCTarget, hold, imem_ack, imem_rdata, fault_clear,
    input  imem_req, imem_addr, Instr, Instr_valid, PC, PCPlus4, fault, fault_cause
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// 8-bit wait counter for outstanding fetches; flags the last allowed cycle.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_term
);

  localparam logic [7:0] TermCount = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_term = (r_count == TermCount);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction-memory handshake, next-PC select and fault detection.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master fetch
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [1:0]   r_fault_cause;

  logic         w_in_fetch;
  logic         w_tmo_term;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;

  assign w_in_fetch = (r_state == StFetch);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_next_pc  = fetch.PCSrc ? fetch.PCTarget : w_pc_plus4;

  // Counter runs only while waiting in FETCH and restarts from zero on every entry.
  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_in_fetch && !fetch.imem_ack),
    .i_clr (!w_in_fetch || fetch.imem_ack || w_tmo_term),
    .o_term(w_tmo_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StBoot;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_fault_cause <= FC_NONE;
    end else begin
      case (r_state)
        StBoot: r_state <= StFetch;
        StFetch: begin
          if (fetch.imem_ack) begin
            r_instr <= fetch.imem_rdata;
            r_state <= StIssue;
          end else if (w_tmo_term) begin
            r_fault_cause <= FC_TIMEOUT;
            r_state       <= StFault;
          end
        end
        StIssue: begin
          if (!fetch.hold) begin
            // A misaligned target leaves PC on the instruction that produced it.
            if (w_next_pc[1:0] != 2'b00) begin
              r_fault_cause <= FC_MISALIGN;
              r_state       <= StFault;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= StFetch;
            end
          end
        end
        StFault: begin
          if (fetch.fault_clear) begin
            r_pc          <= RESET_PC;
            r_fault_cause <= FC_NONE;
            r_state       <= StFetch;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign fetch.imem_req    = w_in_fetch;
  assign fetch.imem_addr   = r_pc;
  assign fetch.Instr       = r_instr;
  assign fetch.Instr_valid = (r_state == StIssue);
  assign fetch.PC          = r_pc;
  assign fetch.PCPlus4     = w_pc_plus4;
  assign fetch.fault       = (r_state == StFault);
  assign fetch.fault_cause = r_fault_cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small instruction-memory model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fetch(ifc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails = 0;
  int unsigned n_wait = 0;
  int unsigned wait_ctr = 0;
  logic        ack_block = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  assign ifc.imem_ack   = ifc.imem_req && !ack_block && (wait_ctr >= n_wait);
  assign ifc.imem_rdata = mem_word(ifc.imem_addr);

  always @(posedge clk) begin
    if (!ifc.imem_req || ifc.imem_ack) wait_ctr <= 0;
    else wait_ctr <= wait_ctr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifc.PCSrc       = 1'b0;
    ifc.PCTarget    = 32'h0;
    ifc.hold        = 1'b0;
    ifc.fault_clear = 1'b0;
    repeat (3) tick();
    check("rst_pc", ifc.PC, 32'h0);
    check("rst_instr", ifc.Instr, 32'h0000_0013);
    check("rst_valid", ifc.Instr_valid, 0);
    check("rst_req", ifc.imem_req, 0);
    check("rst_fault", ifc.fault, 0);
    check("rst_cause", ifc.fault_cause, 0);

    rst_n = 1'b1;
    check("boot_req", ifc.imem_req, 0);
    tick();
    check("fetch0_req", ifc.imem_req, 1);
    check("fetch0_addr", ifc.imem_addr, 32'h0);
    tick();
    check("first_valid", ifc.Instr_valid, 1);
    check("first_instr", ifc.Instr, 32'h0050_0093);
    check("first_pc", ifc.PC, 32'h0);
    check("first_pcp4", ifc.PCPlus4, 32'h4);
    check("issue_req", ifc.imem_req, 0);

    // Sequential fetch
    tick();
    check("seq_addr", ifc.imem_addr, 32'h4);
    check("seq_req", ifc.imem_req, 1);
    tick();
    check("seq_instr", ifc.Instr, 32'h0000_0413);

    // Aligned redirect
    ifc.PCSrc = 1'b1; ifc.PCTarget = 32'h40;
    tick();
    check("redir_addr", ifc.imem_addr, 32'h40);
    ifc.PCSrc = 1'b0;
    tick();
    check("redir_instr", ifc.Instr, 32'h0000_4013);

    // Misaligned redirect
    ifc.PCSrc = 1'b1; ifc.PCTarget = 32'h42;
    tick();
    check("mis_fault", ifc.fault, 1);
    check("mis_cause", ifc.fault_cause, 2'b01);
    check("mis_pc", ifc.PC, 32'h40);
    check("mis_valid", ifc.Instr_valid, 0);
    ifc.PCSrc = 1'b0;
    tick();
    check("mis_stays", ifc.fault, 1);
    ifc.fault_clear = 1'b1;
    tick();
    ifc.fault_clear = 1'b0;
    check("clr_fault", ifc.fault, 0);
    check("clr_cause", ifc.fault_cause, 0);
    check("clr_addr", ifc.imem_addr, 32'h0);
    check("clr_req", ifc.imem_req, 1);
    tick();
    check("clr_valid", ifc.Instr_valid, 1);

    // Hold with PCSrc toggling
    ifc.hold = 1'b1; ifc.PCTarget = 32'h80;
    for (int i = 0; i < 5; i++) begin
      ifc.PCSrc = ~ifc.PCSrc;
      tick();
      check("hold_pc", ifc.PC, 32'h0);
      check("hold_instr", ifc.Instr, 32'h0050_0093);
      check("hold_req", ifc.imem_req, 0);
      check("hold_valid", ifc.Instr_valid, 1);
    end

    // Release with three wait states
    ifc.hold = 1'b0; ifc.PCSrc = 1'b0; n_wait = 3;
    tick();
    check("rel_addr", ifc.imem_addr, 32'h4);
    repeat (3) tick();
    check("wait_req", ifc.imem_req, 1);
    check("wait_valid", ifc.Instr_valid, 0);
    tick();
    check("wait_valid2", ifc.Instr_valid, 1);
    check("wait_instr", ifc.Instr, 32'h0000_0413);
    check("wait_fault", ifc.fault, 0);
    n_wait = 0;

    // Timeout: fault 16 cycles after FETCH entry
    ack_block = 1'b1;
    tick();
    check("tmo_addr", ifc.imem_addr, 32'h8);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_early_fault", ifc.fault, 0);
    check("tmo_early_req", ifc.imem_req, 1);
    tick();
    check("tmo_fault", ifc.fault, 1);
    check("tmo_cause", ifc.fault_cause, 2'b10);
    check("tmo_pc", ifc.PC, 32'h8);
    ack_block = 1'b0;
    ifc.fault_clear = 1'b1;
    tick();
    ifc.fault_clear = 1'b0;
    tick();
    check("tmo_recover", ifc.Instr_valid, 1);

    // Reset during a fetch wait
    ifc.PCSrc = 1'b1; ifc.PCTarget = 32'h100; ack_block = 1'b1;
    tick();
    ifc.PCSrc = 1'b0;
    check("pre_rst_addr", ifc.imem_addr, 32'h100);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_pc", ifc.PC, 32'h0);
    check("midrst_instr", ifc.Instr, 32'h0000_0013);
    check("midrst_req", ifc.imem_req, 0);
    ack_block = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rerun_valid", ifc.Instr_valid, 1);

    // PCPlus4 wrap
    ifc.PCSrc = 1'b1; ifc.PCTarget = 32'hFFFF_FFFC;
    tick();
    ifc.PCSrc = 1'b0;
    tick();
    check("wrap_pc", ifc.PC, 32'hFFFF_FFFC);
    check("wrap_pcp4", ifc.PCPlus4, 32'h0);
    tick();
    check("wrap_addr", ifc.imem_addr, 32'h0);
    check("wrap_fault", ifc.fault, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
